// File: rtl/fetch_stage.sv
// Instruction-fetch stage with PC, IF/ID register and BOOT/RUN/HALT control.
// Optional performance counters are enabled by defining FETCH_PERF_COUNTERS_EN.
module fetch_stage #(
  parameter int unsigned         PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]         NOP_INSTR    = 32'h0000_0000,
  parameter logic [5:0]          HALT_OPCODE  = 6'h3F
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_pipeline,
  input  logic                is_jump,
  input  logic [PC_WIDTH-1:0] jump_addr,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_addr,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_data,
  output logic [31:0]         if_id_instr,
  output logic [PC_WIDTH-1:0] if_id_pc_next,
  output logic                if_id_valid,
  output logic [5:0]          opcode,
  output logic [5:0]          funct,
  output logic                halted
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]         cnt_fetched,
  output logic [31:0]         cnt_flushed,
  output logic [31:0]         cnt_stalled
`endif
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  // What the datapath does on the coming edge; one action per cycle.
  typedef enum logic [2:0] {
    A_IDLE, A_REDIRECT_BR, A_STALL, A_HALT_HOLD, A_REDIRECT_JMP, A_FETCH, A_BUBBLE
  } act_t;

  state_t              state_q, state_d;
  act_t                act;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [PC_WIDTH-1:0] pc_next_q, pc_next_d;
  logic                valid_q, valid_d;
  logic [PC_WIDTH-1:0] pc_inc;

  assign pc_inc = pc_q + PC_WIDTH'(1);

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_BOOT;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    act     = A_IDLE;
    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (branch_taken)        act = A_REDIRECT_BR;
        else if (stall_pipeline) act = A_STALL;
        else if (valid_q && instr_q[31:26] == HALT_OPCODE) begin
          act     = A_HALT_HOLD;
          state_d = S_HALT;
        end
        else if (is_jump)        act = A_REDIRECT_JMP;
        else                     act = A_FETCH;
      end
      S_HALT: begin
        // A taken branch means the halt was fetched down the wrong path.
        if (branch_taken) begin
          act     = A_REDIRECT_BR;
          state_d = S_RUN;
        end else begin
          act = A_BUBBLE;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_next_d = pc_next_q;
    valid_d   = valid_q;
    unique case (act)
      A_REDIRECT_BR: begin
        pc_d    = branch_addr;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      A_REDIRECT_JMP: begin
        pc_d    = jump_addr;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      A_FETCH: begin
        pc_d      = pc_inc;
        instr_d   = imem_data;
        pc_next_d = pc_inc;
        valid_d   = 1'b1;
      end
      A_BUBBLE: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_VECTOR;
      instr_q   <= NOP_INSTR;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
    end
  end

  // Outputs come straight from flops so the control unit sees glitch-free fields.
  assign imem_addr     = pc_q;
  assign if_id_instr   = instr_q;
  assign if_id_pc_next = pc_next_q;
  assign if_id_valid   = valid_q;
  assign opcode        = instr_q[31:26];
  assign funct         = instr_q[5:0];
  assign halted        = (state_q == S_HALT);

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] cnt_fetched_q, cnt_fetched_d;
  logic [31:0] cnt_flushed_q, cnt_flushed_d;
  logic [31:0] cnt_stalled_q, cnt_stalled_d;

  always_comb begin
    cnt_fetched_d = cnt_fetched_q;
    cnt_flushed_d = cnt_flushed_q;
    cnt_stalled_d = cnt_stalled_q;
    if (act == A_FETCH) cnt_fetched_d = cnt_fetched_q + 32'd1;
    if (act == A_REDIRECT_BR || act == A_REDIRECT_JMP) cnt_flushed_d = cnt_flushed_q + 32'd1;
    if (act == A_STALL) cnt_stalled_d = cnt_stalled_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_fetched_q <= '0;
      cnt_flushed_q <= '0;
      cnt_stalled_q <= '0;
    end else begin
      cnt_fetched_q <= cnt_fetched_d;
      cnt_flushed_q <= cnt_flushed_d;
      cnt_stalled_q <= cnt_stalled_d;
    end
  end

  assign cnt_fetched = cnt_fetched_q;
  assign cnt_flushed = cnt_flushed_q;
  assign cnt_stalled = cnt_stalled_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// halt/reset sequences, and randomized traffic against a rule-level model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_pipeline = 1'b0;
  logic        is_jump = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_next;
  logic        if_id_valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        halted;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] cnt_fetched, cnt_flushed, cnt_stalled;
`endif

  logic [31:0] mem [256];
  assign imem_data = mem[imem_addr[7:0]];

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .stall_pipeline(stall_pipeline),
    .is_jump(is_jump), .jump_addr(jump_addr),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .if_id_instr(if_id_instr), .if_id_pc_next(if_id_pc_next),
    .if_id_valid(if_id_valid), .opcode(opcode), .funct(funct),
    .halted(halted)
`ifdef FETCH_PERF_COUNTERS_EN
    , .cnt_fetched(cnt_fetched), .cnt_flushed(cnt_flushed), .cnt_stalled(cnt_stalled)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic expect_if(input string name, input logic [31:0] e_pc, input logic e_valid,
                           input logic [31:0] e_instr, input logic [31:0] e_pcn,
                           input logic e_halted);
    check({name, ".pc"},      imem_addr,     e_pc);
    check({name, ".valid"},   {31'b0, if_id_valid}, {31'b0, e_valid});
    check({name, ".instr"},   if_id_instr,   e_instr);
    check({name, ".pc_next"}, if_id_pc_next, e_pcn);
    check({name, ".halted"},  {31'b0, halted}, {31'b0, e_halted});
  endtask

  // One clock: drive inputs just after an edge, sample 1 time unit after the next edge.
  task automatic tick(input logic st, input logic jp, input logic [31:0] ja,
                      input logic br, input logic [31:0] ba);
    stall_pipeline = st;
    is_jump        = jp;
    jump_addr      = ja;
    branch_taken   = br;
    branch_addr    = ba;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    stall_pipeline = 1'b0; is_jump = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    expect_if("reset", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_COUNTERS_EN
    check("reset.cnt_fetched", cnt_fetched, 32'd0);
    check("reset.cnt_flushed", cnt_flushed, 32'd0);
    check("reset.cnt_stalled", cnt_stalled, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_pcn;
  logic        m_valid;
  int unsigned m_fetched, m_flushed, m_stalled;

  function automatic void model_reset();
    m_mode = M_BOOT; m_pc = 0; m_instr = 0; m_pcn = 0; m_valid = 0;
    m_fetched = 0; m_flushed = 0; m_stalled = 0;
  endfunction

  function automatic void model_redirect(input logic [31:0] target);
    m_pc = target; m_instr = 32'h0; m_valid = 1'b0; m_flushed++;
  endfunction

  function automatic void model_step(input logic st, input logic jp, input logic [31:0] ja,
                                     input logic br, input logic [31:0] ba);
    if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (m_mode == M_HALT) begin
      if (br) begin model_redirect(ba); m_mode = M_RUN; end
      else begin m_instr = 32'h0; m_valid = 1'b0; end
    end else if (br) begin
      model_redirect(ba);
    end else if (st) begin
      m_stalled++;
    end else if (m_valid && m_instr[31:26] == 6'h3F) begin
      m_mode = M_HALT;
    end else if (jp) begin
      model_redirect(ja);
    end else begin
      m_instr = mem[m_pc[7:0]];
      m_pc    = m_pc + 32'd1;
      m_pcn   = m_pc;
      m_valid = 1'b1;
      m_fetched++;
    end
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        st, jp, br;
    logic [31:0] ja, ba;
    logic [31:0] e_pc, e_instr, e_pcn;
    logic        e_valid;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic jp, input logic [31:0] ja,
                              input logic br, input logic [31:0] ba,
                              input logic [31:0] e_pc, input logic e_valid,
                              input logic [31:0] e_instr, input logic [31:0] e_pcn);
    vec_t v;
    v.st = st; v.jp = jp; v.ja = ja; v.br = br; v.ba = ba;
    v.e_pc = e_pc; v.e_valid = e_valid; v.e_instr = e_instr; v.e_pcn = e_pcn;
    return v;
  endfunction

  vec_t vecs[20];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] w;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;

    // mem[i] = A000_0000 + i; NOP = 0; stalls hold, jumps/branches flush.
    vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,  32'h0,        0, 32'h0,         32'h0);
    vecs[1]  = mk(0, 0, 32'h0,        0, 32'h0,  32'h1,        1, 32'hA000_0000, 32'h1);
    vecs[2]  = mk(0, 0, 32'h0,        0, 32'h0,  32'h2,        1, 32'hA000_0001, 32'h2);
    vecs[3]  = mk(0, 0, 32'h0,        0, 32'h0,  32'h3,        1, 32'hA000_0002, 32'h3);
    vecs[4]  = mk(0, 0, 32'h0,        0, 32'h0,  32'h4,        1, 32'hA000_0003, 32'h4);
    vecs[5]  = mk(0, 0, 32'h0,        0, 32'h0,  32'h5,        1, 32'hA000_0004, 32'h5);
    vecs[6]  = mk(1, 0, 32'h0,        0, 32'h0,  32'h5,        1, 32'hA000_0004, 32'h5);
    vecs[7]  = mk(1, 0, 32'h0,        0, 32'h0,  32'h5,        1, 32'hA000_0004, 32'h5);
    vecs[8]  = mk(1, 0, 32'h0,        0, 32'h0,  32'h5,        1, 32'hA000_0004, 32'h5);
    vecs[9]  = mk(0, 0, 32'h0,        0, 32'h0,  32'h6,        1, 32'hA000_0005, 32'h6);
    vecs[10] = mk(0, 0, 32'h0,        0, 32'h0,  32'h7,        1, 32'hA000_0006, 32'h7);
    vecs[11] = mk(0, 0, 32'h0,        0, 32'h0,  32'h8,        1, 32'hA000_0007, 32'h8);
    vecs[12] = mk(0, 1, 32'h40,       0, 32'h0,  32'h40,       0, 32'h0,         32'h8);
    vecs[13] = mk(0, 0, 32'h0,        0, 32'h0,  32'h41,       1, 32'hA000_0040, 32'h41);
    vecs[14] = mk(1, 1, 32'h40,       1, 32'h10, 32'h10,       0, 32'h0,         32'h41);
    vecs[15] = mk(0, 0, 32'h0,        0, 32'h0,  32'h11,       1, 32'hA000_0010, 32'h11);
    vecs[16] = mk(1, 1, 32'h40,       0, 32'h0,  32'h11,       1, 32'hA000_0010, 32'h11);
    vecs[17] = mk(0, 1, 32'hFFFF_FFFF, 0, 32'h0, 32'hFFFF_FFFF, 0, 32'h0,         32'h11);
    vecs[18] = mk(0, 0, 32'h0,        0, 32'h0,  32'h0,        1, 32'hA000_00FF, 32'h0);
    vecs[19] = mk(0, 0, 32'h0,        0, 32'h0,  32'h1,        1, 32'hA000_0000, 32'h1);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(vecs[i].st, vecs[i].jp, vecs[i].ja, vecs[i].br, vecs[i].ba);
      expect_if($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_valid,
                vecs[i].e_instr, vecs[i].e_pcn, 1'b0);
      w = vecs[i].e_instr;
      check($sformatf("vec%0d.opcode", i), {26'b0, opcode}, {26'b0, w[31:26]});
      check($sformatf("vec%0d.funct", i),  {26'b0, funct},  {26'b0, w[5:0]});
    end

    // Halt word reaches IF/ID, stays one cycle, then bubbles until a branch.
    mem[3] = 32'hFC00_0003;
    do_reset();
    repeat (4) idle();
    idle();
    expect_if("halt.fetch", 32'h4, 1, 32'hFC00_0003, 32'h4, 0);
    idle();
    expect_if("halt.enter", 32'h4, 1, 32'hFC00_0003, 32'h4, 1);
    idle();
    expect_if("halt.bubble", 32'h4, 0, 32'h0, 32'h4, 1);
    tick(1, 1, 32'h40, 0, 32'h0);
    expect_if("halt.ignore", 32'h4, 0, 32'h0, 32'h4, 1);
    tick(0, 0, 32'h0, 1, 32'h20);
    expect_if("halt.branch", 32'h20, 0, 32'h0, 32'h4, 0);
    idle();
    expect_if("halt.resume", 32'h21, 1, 32'hA000_0020, 32'h21, 0);

    // Stall defers halt detection; branch in the detection cycle discards it.
    do_reset();
    repeat (5) idle();
    tick(1, 0, 32'h0, 0, 32'h0);
    expect_if("hbr.stall", 32'h4, 1, 32'hFC00_0003, 32'h4, 0);
    tick(0, 0, 32'h0, 1, 32'h30);
    expect_if("hbr.branch", 32'h30, 0, 32'h0, 32'h4, 0);
    idle();
    expect_if("hbr.resume", 32'h31, 1, 32'hA000_0030, 32'h31, 0);
    mem[3] = 32'hA000_0003;

`ifdef FETCH_PERF_COUNTERS_EN
    do_reset();
    idle();
    repeat (10) idle();
    repeat (2) tick(1, 0, 32'h0, 0, 32'h0);
    tick(0, 1, 32'h40, 0, 32'h0);
    check("cnt.fetched", cnt_fetched, 32'd10);
    check("cnt.stalled", cnt_stalled, 32'd2);
    check("cnt.flushed", cnt_flushed, 32'd1);
`endif

    // Randomized traffic with scattered halt words.
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if ($urandom_range(0, 15) == 0) w[31:26] = 6'h3F;
      mem[i] = w;
    end
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic st, jp, br;
      logic [31:0] ja, ba;
      st = ($urandom_range(0, 4) == 0);
      jp = ($urandom_range(0, 7) == 0);
      br = ($urandom_range(0, 9) == 0);
      ja = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
      ba = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
      model_step(st, jp, ja, br, ba);
      tick(st, jp, ja, br, ba);
      expect_if($sformatf("rnd%0d", c), m_pc, m_valid, m_instr, m_pcn, m_mode == M_HALT);
      check($sformatf("rnd%0d.opcode", c), {26'b0, opcode}, {26'b0, m_instr[31:26]});
`ifdef FETCH_PERF_COUNTERS_EN
      check($sformatf("rnd%0d.cnt_fetched", c), cnt_fetched, m_fetched);
      check($sformatf("rnd%0d.cnt_flushed", c), cnt_flushed, m_flushed);
      check($sformatf("rnd%0d.cnt_stalled", c), cnt_stalled, m_stalled);
`endif
    end

    // Asynchronous reset mid-cycle with redirects pending; BOOT then ignores them.
    is_jump = 1'b1; jump_addr = 32'h50; branch_taken = 1'b1; branch_addr = 32'h60;
    #3;
    rst = 1'b1;
    #1;
    expect_if("async_rst", 32'h0, 0, 32'h0, 32'h0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1, 1, 32'h50, 1, 32'h60);
    expect_if("boot_ignores", 32'h0, 0, 32'h0, 32'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the LAPI DOpaCA LAMBA core. The block holds the program counter, drives the instruction-memory address, and latches the fetched word together with PC+1. It handles redirects from unconditional jumps (resolved in ID) and taken branches (resolved in MEM), and stalls from the hazard logic. Its registered `opcode`/`funct` outputs feed the control unit directly.

## Interface
Parameters:
- `PC_WIDTH`, 32: width of the PC and of all addresses. Memory is word-addressed.
- `RESET_VECTOR`, 0: PC value after reset.
- `NOP_INSTR`, 32'h0000_0000: word inserted into IF/ID on a flush.
- `HALT_OPCODE`, 6'h3F: opcode that halts fetch.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `stall_pipeline`  in  1  hold PC and IF/ID.
- `is_jump`  in  1  instruction in ID is an unconditional jump.
- `jump_addr`  in  PC_WIDTH  jump target from ID.
- `branch_taken`  in  1  branch in MEM is taken.
- `branch_addr`  in  PC_WIDTH  branch target from MEM.
- `imem_addr`  out  PC_WIDTH  equals `pc`, combinational.
- `imem_data`  in  32  instruction word; combinational read of `imem_addr`.
- `if_id_instr`  out  32  latched instruction.
- `if_id_pc_next`  out  PC_WIDTH  PC+1 of the latched instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `opcode`  out  6  `if_id_instr[31:26]`.
- `funct`  out  6  `if_id_instr[5:0]`.
- `halted`  out  1  FSM is in HALT.

## Operation
FSM states are BOOT, RUN and HALT.
- **Reset** (while `rst` is high): state=BOOT, `pc`=RESET_VECTOR, `if_id_instr`=NOP_INSTR, `if_id_pc_next`=0, `if_id_valid`=0, `halted`=0.
- **BOOT**: lasts exactly one cycle after `rst` falls. PC is not advanced and IF/ID stays a bubble. Next state is RUN.
- **RUN**: each edge applies the first matching rule, in this priority order:
  1. `branch_taken`: `pc`<=`branch_addr`; flush IF/ID (`if_id_instr`<=NOP_INSTR, `if_id_valid`<=0). This overrides a stall.
  2. `stall_pipeline`: hold `pc` and all IF/ID registers. A simultaneous `is_jump` is ignored.
  3. `is_jump`: `pc`<=`jump_addr`; flush IF/ID.
  4. Otherwise: `if_id_instr`<=`imem_data`, `if_id_pc_next`<=`pc`+1, `if_id_valid`<=1, `pc`<=`pc`+1.
- **PC arithmetic**: modulo 2^PC_WIDTH. The address all-ones wraps to 0 with no flag.
- **Halt detection** (RUN only): when `if_id_valid`=1, `opcode`=HALT_OPCODE and no stall is active, next state is HALT. The halt word itself stays in IF/ID for one more cycle so that ID sees it.
- **HALT**: `pc` is frozen. IF/ID is loaded with a bubble every cycle. `halted`=1.
  - `branch_taken` in HALT redirects exactly as in RUN and returns the FSM to RUN, because the halt was wrong-path.
  - Otherwise HALT is left only by `rst`.
- **Simultaneous halt and branch**: a halt detection in the same cycle as `branch_taken` is discarded. The FSM stays in RUN and the redirect wins.

## Timing
- Fetch latency: an instruction at `pc` appears on `if_id_instr` one edge later.
- Jump penalty: 1 bubble in IF/ID.
- Branch penalty in this block: 1 bubble in IF/ID. Flushing ID/EX and EX/MEM belongs to the downstream stages.
- `opcode` and `funct` change only on `clk` edges or on `rst`. They are glitch-free inputs to the control unit.
- Asynchronous `rst` mid-cycle immediately forces the reset values listed under Operation. Any pending redirect is lost.

## Configuration
- `FETCH_PERF_COUNTERS_EN` defined: adds three 32-bit output ports, all wrapping and reset to 0.
  - `cnt_fetched`: increments on each rule-4 edge.
  - `cnt_flushed`: increments on each rule-1 or rule-3 edge, and on each edge of a `branch_taken` redirect in HALT.
  - `cnt_stalled`: increments on each rule-2 edge.
- `FETCH_PERF_COUNTERS_EN` undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- **Reset and boot**: assert `rst`, release it, keep `imem_data`=mem[pc].
  - `pc`=0 during BOOT, `if_id_valid`=0 for the first edge.
  - Then `if_id_instr`=mem[0] and `if_id_pc_next`=1, followed by mem[1] and 2.
- **Stall**: raise `stall_pipeline` for 3 cycles with `pc`=5.
  - `pc` stays 5 and IF/ID is unchanged.
  - Release: the next edge latches mem[5] and `pc`=6.
- **Jump**: `is_jump`=1 with `jump_addr`=0x40 while `pc`=8.
  - Next edge: `pc`=0x40, `if_id_valid`=0, `if_id_instr`=NOP_INSTR.
  - Following edge latches mem[0x40].
- **Branch beats stall and jump**: `branch_taken`=1 with `branch_addr`=0x10, `stall_pipeline`=1, `is_jump`=1 with `jump_addr`=0x40, all in one cycle.
  - `pc`=0x10 and IF/ID is flushed.
- **Halt, then branch**: place HALT_OPCODE at mem[3].
  - After it reaches IF/ID: `halted`=1, `pc` frozen at 4, bubbles follow.
  - A later `branch_taken` with `branch_addr`=0x20 gives `halted`=0 and `pc`=0x20.
- **Counters** (with `FETCH_PERF_COUNTERS_EN`): run 10 normal fetches, 2 stall cycles and 1 jump.
  - Expected: `cnt_fetched`=10, `cnt_stalled`=2, `cnt_flushed`=1.
